mmult_accel_udiv_62ns_31ns_seq: RTL and testbench
=================================================

# mmult_accel_udiv_62ns_31ns_seq

Sequential unsigned restoring divider for the matmul accelerator. It is the inverse of the pipelined 31x31→62 unsigned multiplier: it takes a 62-bit product-width dividend and a 31-bit divisor and returns a 62-bit quotient and a 31-bit remainder. Results are used for rescaling and normalising accumulated matmul results. It computes one quotient bit per enabled cycle, uses a start/ready/done handshake, and shares the multiplier's `ce` stall semantics.

## Interface
- `ID`, 1: instance tag; no functional effect.
- `din0_WIDTH`, 62: dividend width, which is also the quotient width and the iteration count W.
- `din1_WIDTH`, 31: divisor width, which is also the remainder width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `ce`  in  1  clock enable; when 0, all state, counters and outputs hold.
- `start`  in  1  request; accepted on an edge where `start & ready & ce`.
- `din0`  in  din0_WIDTH  unsigned dividend; sampled only on acceptance.
- `din1`  in  din1_WIDTH  unsigned divisor; sampled only on acceptance.
- `ready`  out  1  high in IDLE and DONE; combinational from state.
- `done`  out  1  high while the FSM is in DONE.
- `quo`  out  din0_WIDTH  quotient; registered, held until the next completion.
- `rem`  out  din1_WIDTH  remainder; registered, held until the next completion.
- `dbz`  out  1  divide-by-zero flag for the current result; held with `quo`/`rem`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on acceptance:
  - load the dividend shift register with `din0` and latch `din1`;
  - clear the partial remainder P (din1_WIDTH+1 bits);
  - set the step counter to W.
- RUN: each ce cycle performs one restoring step, then decrements the counter:
  - P' = {P[din1_WIDTH-1:0], dividend MSB};
  - shift the dividend register left by 1;
  - if P' ≥ {0,divisor}: P = P' − divisor and shift 1 into the quotient LSB; otherwise P = P' and shift in 0.
- RUN → DONE after the W-th step:
  - load `quo`, `rem` = P[din1_WIDTH-1:0] and `dbz`.
- DONE → RUN on the next ce cycle if `start` is asserted (back-to-back; new operands accepted); otherwise DONE → IDLE.
- `start` during RUN is ignored; no queuing.
- Divisor = 0: the result is forced to `quo` = all ones, `rem` = din0[din1_WIDTH-1:0], `dbz` = 1. Latency is unchanged.
- Arithmetic is unsigned only. For nonzero divisors, din0 = quo·din1 + rem with rem < din1.
- Widths are never truncated: `quo` spans the full dividend width (divisor 1 is legal).

## Timing
- Reset (asynchronous, while `reset`=0):
  - state = IDLE;
  - `quo`, `rem`, `dbz`, `done` = 0, and all internal registers = 0;
  - `ready` = 1.
- Reset release is synchronous to `clk`; the first acceptance is legal on the first edge after release.
- Latency: with start accepted at edge T and `ce` held high, `done` rises after edge T+W+1 (63 cycles for W=62). `quo`/`rem`/`dbz` are valid in that same cycle.
- `done` stays high for exactly one ce cycle if no new start arrives. With `ce`=0 it stays high for as long as `ce` is low.
- `ce`=0 cycles anywhere in RUN extend latency by exactly the number of stalled cycles; no step is lost or repeated.
- Throughput: one result per W+1 ce cycles with back-to-back starts.
- Outputs change only on the completion edge. Between completions they are stable, including during RUN of the next operation.
- Reset mid-RUN aborts the operation: no `done`, outputs are cleared, and the previous result is lost.
- `start` and reset release on the same edge: the start is ignored.

## Test plan
- Basic: din0=100, din1=7, start for 1 cycle → `done` at T+63 with `quo`=14, `rem`=2, `dbz`=0; `ready`=0 from T+1 to T+62.
- Extremes:
  - din0=2^62−1, din1=2^31−1 → `quo`=2^31+1, `rem`=0.
  - din0=2^62−1, din1=1 → `quo`=2^62−1, `rem`=0.
  - din0=5, din1=9 → `quo`=0, `rem`=5.
- Divide by zero: din0=0x1234, din1=0 → `quo`=all ones, `rem`=0x1234, `dbz`=1 at T+63; the next op 100/7 clears `dbz`.
- Stall: 100/7 with `ce`=0 for 5 cycles at step 20 → `done` at T+68 with the same result; `done` held through a 3-cycle `ce`=0 window in DONE.
- Reset mid-op: assert `reset`=0 at step 20 of 2^40/3 → outputs 0 and `ready`=1 immediately; no `done`. A subsequent 100/7 gives 14 r 2.
- Back-to-back and ignored start: start held high for 200 cycles with operands changing on each acceptance → results at T+63, T+126, T+189, each matching the operands latched at its acceptance edge. Operand changes during RUN have no effect. A random set of 1000 operand pairs is checked against a reference model.

Source files
------------

// File: rtl/mmult_accel_udiv_62ns_31ns_seq.sv
// ---------------------------------------------------------------------------
// mmult_accel_udiv_62ns_31ns_seq
//
// Sequential unsigned restoring divider used to rescale/normalise matmul
// accumulations. It produces one quotient bit per enabled clock, so a full
// division takes din0_WIDTH ce cycles of iteration plus one cycle in DONE.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous reset, active low
//   ce     : clock enable; when low every register (state, counter, outputs)
//            holds
//   start  : request, accepted on an edge with start & ready & ce
//   din0   : dividend (din0_WIDTH bits), sampled on acceptance only
//   din1   : divisor  (din1_WIDTH bits), sampled on acceptance only
//   ready  : high in IDLE and DONE
//   done   : high while the result is being presented (DONE state)
//   quo    : quotient, registered, held until the next completion
//   rem    : remainder, registered, held until the next completion
//   dbz    : divisor was zero for the current result
// ---------------------------------------------------------------------------
module mmult_accel_udiv_62ns_31ns_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 62,
    parameter int din1_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [din0_WIDTH-1:0] quo,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dbz
);

    // ID is an instance tag only; it is folded in with weight zero so the
    // counter width stays a pure function of the dividend width.
    localparam int CW = $clog2(din0_WIDTH + 1) + 0 * ID;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Dividend bits leave at the top while quotient bits enter at the bottom,
    // so a single register carries both during the iteration.
    logic [din0_WIDTH-1:0] dq_reg;
    logic [din1_WIDTH-1:0] divisor_reg;
    // The partial remainder is always strictly below the divisor after a
    // step, so its extra top bit is provably zero and is not stored.
    logic [din1_WIDTH-1:0] part_reg;
    logic [CW-1:0]         count_reg;
    logic                  zero_reg;

    logic [din1_WIDTH:0]   shifted;
    logic                  take;
    logic [din1_WIDTH-1:0] step_part;
    logic [din0_WIDTH-1:0] step_dq;
    logic                  accept;
    logic                  last_step;

    // One restoring step. When take is set the true difference is below
    // 2^din1_WIDTH, so the modular subtraction on the low bits is exact.
    always_comb begin
        shifted   = {part_reg, dq_reg[din0_WIDTH-1]};
        take      = (shifted >= {1'b0, divisor_reg});
        step_part = take ? (shifted[din1_WIDTH-1:0] - divisor_reg)
                         : shifted[din1_WIDTH-1:0];
        step_dq   = {dq_reg[din0_WIDTH-2:0], take};
    end

    assign ready     = (state_reg == IDLE) || (state_reg == DONE);
    assign done      = (state_reg == DONE);
    assign accept    = ce && start && ready;
    assign last_step = (count_reg == CW'(1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (ce && last_step) state_next = DONE;
            DONE: if (ce) state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dq_reg      <= '0;
            divisor_reg <= '0;
            part_reg    <= '0;
            count_reg   <= '0;
            zero_reg    <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            dbz         <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                dq_reg      <= din0;
                divisor_reg <= din1;
                part_reg    <= '0;
                count_reg   <= CW'(din0_WIDTH);
                zero_reg    <= (din1 == '0);
            end else if (state_reg == RUN) begin
                dq_reg    <= step_dq;
                part_reg  <= step_part;
                count_reg <= count_reg - CW'(1);
                if (last_step) begin
                    // With a zero divisor every step subtracts nothing, so
                    // the remainder naturally ends as the low dividend bits;
                    // the quotient is forced to all ones regardless.
                    quo <= zero_reg ? '1 : step_dq;
                    rem <= step_part;
                    dbz <= zero_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmult_accel_udiv_62ns_31ns_seq.sv
// ---------------------------------------------------------------------------
// Testbench for mmult_accel_udiv_62ns_31ns_seq. Inputs are driven 1 ns after
// a rising edge and outputs are sampled at that same point. Expected results
// come from plain integer / and % on the operands.
// ---------------------------------------------------------------------------
module tb_mmult_accel_udiv_62ns_31ns_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [61:0] din0 = '0;
    logic [30:0] din1 = '0;
    logic        ready, done, dbz;
    logic [61:0] quo;
    logic [30:0] rem;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [61:0] q;
        logic [30:0] r;
        logic        z;
    } exp_t;

    mmult_accel_udiv_62ns_31ns_seq #(
        .ID(1), .din0_WIDTH(62), .din1_WIDTH(31)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1),
        .ready(ready), .done(done), .quo(quo), .rem(rem), .dbz(dbz)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [61:0] a, input logic [30:0] b);
        exp_t e;
        if (b == 31'd0) begin
            e.q = '1;
            e.r = a[30:0];
            e.z = 1'b1;
        end else begin
            e.q = a / {31'd0, b};
            e.r = 31'(a % {31'd0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [61:0] rand_a();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if ($urandom_range(3) == 0) return {46'd0, v[15:0]};
        return v[61:0];
    endfunction

    function automatic logic [30:0] rand_b();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(7))
            0:       return 31'd0;
            1:       return 31'($urandom_range(15, 1));
            2:       return 31'h7fff_ffff;
            default: return v[30:0];
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait for done. lat counts edges from the
    // accepting one (lat=1 right after acceptance); the cycle in which start
    // is presented is T, so done in cycle T+63 gives lat=63.
    task automatic do_op(input logic [61:0] a, input logic [30:0] b,
                         output int lat, output int ready_low);
        start = 1'b1;
        din0  = a;
        din1  = b;
        tick();
        start = 1'b0;
        din0  = rand_a();
        din1  = rand_b();
        lat = 1;
        ready_low = 0;
        while (!done && lat < 300) begin
            if (!ready) ready_low++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (quo !== 62'd0 || rem !== 31'd0 || dbz !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: quo=%h rem=%h dbz=%b done=%b ready=%b, want 0 0 0 0 1",
                     quo, rem, dbz, done, ready);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat, rl;
        do_op(62'd100, 31'd7, lat, rl);
        $display("op 100/7: lat=%0d quo=%0d rem=%0d dbz=%b", lat, quo, rem, dbz);
        total++;
        if (done !== 1'b1 || lat !== 63) begin
            bad++;
            $display("FAIL basic_latency: done=%b lat=%0d, want done=1 lat=63", done, lat);
        end
        total++;
        if (quo !== 62'd14 || rem !== 31'd2 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: quo=%0d rem=%0d dbz=%b, want 14 2 0", quo, rem, dbz);
        end
        total++;
        if (rl !== 62) begin
            bad++;
            $display("FAIL basic_ready_low: got %0d cycles, want 62", rl);
        end
        tick();
        total++;
        if (done !== 1'b0 || ready !== 1'b1 || quo !== 62'd14) begin
            bad++;
            $display("FAIL basic_done_pulse: done=%b ready=%b quo=%0d, want 0 1 14", done, ready, quo);
        end
    endtask

    task automatic test_extremes();
        logic [61:0] a_tab [3];
        logic [30:0] b_tab [3];
        logic [61:0] q_tab [3];
        logic [30:0] r_tab [3];
        int lat, rl;
        a_tab[0] = '1;       b_tab[0] = '1;     q_tab[0] = 62'h8000_0001; r_tab[0] = 31'd0;
        a_tab[1] = '1;       b_tab[1] = 31'd1;  q_tab[1] = '1;            r_tab[1] = 31'd0;
        a_tab[2] = 62'd5;    b_tab[2] = 31'd9;  q_tab[2] = 62'd0;         r_tab[2] = 31'd5;
        for (int i = 0; i < 3; i++) begin
            do_op(a_tab[i], b_tab[i], lat, rl);
            $display("op %h/%h: lat=%0d quo=%h rem=%h dbz=%b", a_tab[i], b_tab[i], lat, quo, rem, dbz);
            total++;
            if (done !== 1'b1 || lat !== 63 || quo !== q_tab[i] || rem !== r_tab[i] || dbz !== 1'b0) begin
                bad++;
                $display("FAIL extreme_%0d: done=%b lat=%0d quo=%h rem=%h dbz=%b, want 1 63 %h %h 0",
                         i, done, lat, quo, rem, dbz, q_tab[i], r_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_by_zero();
        int lat, rl;
        do_op(62'h1234, 31'd0, lat, rl);
        $display("op 1234/0: lat=%0d quo=%h rem=%h dbz=%b", lat, quo, rem, dbz);
        total++;
        if (done !== 1'b1 || lat !== 63 || quo !== '1 || rem !== 31'h1234 || dbz !== 1'b1) begin
            bad++;
            $display("FAIL dbz_result: done=%b lat=%0d quo=%h rem=%h dbz=%b, want 1 63 all-ones 1234 1",
                     done, lat, quo, rem, dbz);
        end
        tick();
        do_op(62'd100, 31'd7, lat, rl);
        $display("op 100/7: lat=%0d quo=%0d rem=%0d dbz=%b", lat, quo, rem, dbz);
        total++;
        if (done !== 1'b1 || quo !== 62'd14 || rem !== 31'd2 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL dbz_cleared: done=%b quo=%0d rem=%0d dbz=%b, want 1 14 2 0", done, quo, rem, dbz);
        end
        tick();
    endtask

    task automatic test_stall();
        int lat;
        int held_bad;
        start = 1'b1;
        din0  = 62'd100;
        din1  = 31'd7;
        tick();
        start = 1'b0;
        lat = 1;
        repeat (19) begin tick(); lat++; end
        ce = 1'b0;
        held_bad = 0;
        repeat (5) begin
            tick();
            lat++;
            if (done !== 1'b0 || quo !== 62'd14 || rem !== 31'd2) held_bad++;
        end
        ce = 1'b1;
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL stall_outputs_held: %0d cycles changed, want 0", held_bad);
        end
        while (!done && lat < 300) begin tick(); lat++; end
        $display("op 100/7 stalled 5: lat=%0d quo=%0d rem=%0d", lat, quo, rem);
        total++;
        if (done !== 1'b1 || lat !== 68 || quo !== 62'd14 || rem !== 31'd2) begin
            bad++;
            $display("FAIL stall_latency: done=%b lat=%0d quo=%0d rem=%0d, want 1 68 14 2", done, lat, quo, rem);
        end
        ce = 1'b0;
        held_bad = 0;
        repeat (3) begin
            tick();
            if (done !== 1'b1) held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL stall_done_held: done low in %0d of 3 stalled cycles, want 0", held_bad);
        end
        ce = 1'b1;
        tick();
        total++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_done_release: done=%b ready=%b, want 0 1", done, ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rl, seen;
        start = 1'b1;
        din0  = 62'd1 << 40;
        din1  = 31'd3;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b0;
        #1;
        total++;
        if (quo !== 62'd0 || rem !== 31'd0 || dbz !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_state: quo=%h rem=%h dbz=%b done=%b ready=%b, want 0 0 0 0 1",
                     quo, rem, dbz, done, ready);
        end
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (80) begin
            tick();
            if (done) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_done: done seen %0d cycles, want 0", seen);
        end
        do_op(62'd100, 31'd7, lat, rl);
        $display("op 100/7 after reset: lat=%0d quo=%0d rem=%0d", lat, quo, rem);
        total++;
        if (done !== 1'b1 || lat !== 63 || quo !== 62'd14 || rem !== 31'd2) begin
            bad++;
            $display("FAIL reset_mid_recover: done=%b lat=%0d quo=%0d rem=%0d, want 1 63 14 2", done, lat, quo, rem);
        end
        tick();
    endtask

    // start held high for 200 cycles, operands scrambled every cycle.
    task automatic test_back_to_back();
        exp_t exp_q[$];
        exp_t e;
        int done_cyc[$];
        int cyc;
        logic acc;
        cyc = 0;
        start = 1'b1;
        din0 = rand_a();
        din1 = rand_b();
        while (cyc < 300) begin
            if (cyc == 200) start = 1'b0;
            acc = start && ready;
            if (acc) exp_q.push_back(model(din0, din1));
            tick();
            cyc++;
            if (done) begin
                done_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_done: cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("b2b result at cycle %0d: quo=%h rem=%h dbz=%b", cyc, quo, rem, dbz);
                    if (quo !== e.q || rem !== e.r || dbz !== e.z) begin
                        bad++;
                        $display("FAIL b2b_result: quo=%h rem=%h dbz=%b, want %h %h %b",
                                 quo, rem, dbz, e.q, e.r, e.z);
                    end
                end
            end
            din0 = rand_a();
            din1 = rand_b();
        end
        total++;
        if (done_cyc.size() != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: %0d results, %0d pending, want 4 0", done_cyc.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (done_cyc[i] != 63 * (i + 1)) begin
                    bad++;
                    $display("FAIL b2b_timing_%0d: done at cycle %0d, want %0d", i, done_cyc[i], 63 * (i + 1));
                end
            end
        end
    endtask

    // 1000 random pairs streamed back-to-back with occasional ce stalls.
    task automatic test_random();
        exp_t exp_q[$];
        exp_t e;
        int pushed, got, cyc;
        logic acc;
        pushed = 0;
        got = 0;
        cyc = 0;
        start = 1'b1;
        din0 = rand_a();
        din1 = rand_b();
        while (got < 1000 && cyc < 80000) begin
            ce = ($urandom_range(15) != 0);
            if (pushed == 1000) start = 1'b0;
            acc = start && ready && ce;
            if (acc) begin
                exp_q.push_back(model(din0, din1));
                pushed++;
            end
            tick();
            cyc++;
            if (done && ce) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_unexpected_done: cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (quo !== e.q || rem !== e.r || dbz !== e.z) begin
                        bad++;
                        $display("FAIL rand_result_%0d: quo=%h rem=%h dbz=%b, want %h %h %b",
                                 got, quo, rem, dbz, e.q, e.r, e.z);
                    end
                end
            end
            din0 = rand_a();
            din1 = rand_b();
        end
        ce = 1'b1;
        start = 1'b0;
        $display("random stream: %0d results in %0d cycles", got, cyc);
        total++;
        if (got != 1000) begin
            bad++;
            $display("FAIL rand_count: %0d results before cycle budget, want 1000", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
